// File: rtl/vga_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_out_ctrl
// Description : Display-side timing and output stage for the image filter
//               pipe. Divides Clock by two into a pixel enable, runs the
//               raster H/V counters, issues one read strobe per active pixel
//               to the filter output line buffer, and registers the returned
//               RGB plus sync/blank/frame-start onto the VGA DAC pins.
// Ports       : Clock, Resetn (async, active-low), Enable
//               Clock_en, H_Count[10:0], V_Count[9:0], Frame_start
//               oRead_out_en       -> filter iRead_out_en
//               R_in/G_in/B_in     <- filter output buffer data
//               VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N -> DAC
// Revision    : 1.0 - initial release
// ============================================================================
module vga_out_ctrl #(
    parameter int H_SYNC   = 120,
    parameter int H_BACK   = 96,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 64,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        Clock_en,
    output logic [10:0] H_Count,
    output logic [9:0]  V_Count,
    output logic        oRead_out_en,
    input  logic [7:0]  R_in,
    input  logic [7:0]  G_in,
    input  logic [7:0]  B_in,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        Frame_start
);

    localparam logic [10:0] c_h_last        = 11'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [10:0] c_h_sync        = 11'(H_SYNC);
    // The fetch window runs one pixel ahead of the active window: the strobe
    // issued while the counter shows pixel N-1 delivers data for pixel N.
    localparam logic [10:0] c_h_fetch_first = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_h_fetch_last  = 11'(H_SYNC + H_BACK + H_ACTIVE - 2);
    localparam logic [9:0]  c_v_last        = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0]  c_v_sync        = 10'(V_SYNC);
    localparam logic [9:0]  c_v_act_first   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  c_v_act_last    = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

    logic        r_clock_en;
    logic [10:0] r_h_count;
    logic [9:0]  r_v_count;
    logic        r_read_en;
    logic [7:0]  r_vga_r;
    logic [7:0]  r_vga_g;
    logic [7:0]  r_vga_b;
    logic        r_vga_hs;
    logic        r_vga_vs;
    logic        r_blank_n;
    logic        r_frame_start;

    logic        w_h_wrap;
    logic [10:0] w_h_next;
    logic [9:0]  w_v_next;
    logic        w_fetch_now;
    logic        w_fetch_next;

    function automatic logic f_in_fetch(input logic [10:0] h, input logic [9:0] v);
        return (v >= c_v_act_first) && (v <= c_v_act_last) &&
               (h >= c_h_fetch_first) && (h <= c_h_fetch_last);
    endfunction

    // Raster position after the next pixel advance.
    always_comb begin
        w_h_wrap = (r_h_count == c_h_last);
        w_h_next = w_h_wrap ? 11'd0 : r_h_count + 11'd1;
        w_v_next = r_v_count;
        if (w_h_wrap) begin
            w_v_next = (r_v_count == c_v_last) ? 10'd0 : r_v_count + 10'd1;
        end
        w_fetch_now  = f_in_fetch(r_h_count, r_v_count);
        w_fetch_next = f_in_fetch(w_h_next, w_v_next);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_clock_en    <= 1'b0;
            r_h_count     <= 11'd0;
            r_v_count     <= 10'd0;
            r_read_en     <= 1'b0;
            r_vga_r       <= 8'd0;
            r_vga_g       <= 8'd0;
            r_vga_b       <= 8'd0;
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!Enable) begin
            // Disabled: park the raster at the origin with blanked outputs so
            // re-enable restarts exactly like a fresh reset.
            r_clock_en    <= 1'b0;
            r_h_count     <= 11'd0;
            r_v_count     <= 10'd0;
            r_read_en     <= 1'b0;
            r_vga_r       <= 8'd0;
            r_vga_g       <= 8'd0;
            r_vga_b       <= 8'd0;
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_clock_en    <= ~r_clock_en;
            // Strobe lands in the Clock_en=0 half of the pixel, so it looks at
            // the position the counter is about to take.
            r_read_en     <= r_clock_en & w_fetch_next;
            // Counters hold while Clock_en=0, so the origin test on the
            // current position is the position of the coming Clock_en=1 cycle.
            r_frame_start <= ~r_clock_en & (r_h_count == 11'd0) & (r_v_count == 10'd0);
            if (r_clock_en) begin
                r_h_count <= w_h_next;
                r_v_count <= w_v_next;
                // RAM data for the strobe of the previous Clock is on the
                // inputs now; blank follows the same fetch qualification.
                r_blank_n <= w_fetch_now;
                r_vga_r   <= w_fetch_now ? R_in : 8'd0;
                r_vga_g   <= w_fetch_now ? G_in : 8'd0;
                r_vga_b   <= w_fetch_now ? B_in : 8'd0;
                r_vga_hs  <= (r_h_count >= c_h_sync);
                r_vga_vs  <= (r_v_count >= c_v_sync);
            end
        end
    end

    assign Clock_en     = r_clock_en;
    assign H_Count      = r_h_count;
    assign V_Count      = r_v_count;
    assign oRead_out_en = r_read_en;
    assign VGA_R        = r_vga_r;
    assign VGA_G        = r_vga_g;
    assign VGA_B        = r_vga_b;
    assign VGA_HS       = r_vga_hs;
    assign VGA_VS       = r_vga_vs;
    assign VGA_BLANK_N  = r_blank_n;
    assign VGA_SYNC_N   = 1'b0;
    assign Frame_start  = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_out_ctrl
// Description : Self-checking bench for vga_out_ctrl on a reduced raster.
//               A reference model derives every expected output from the
//               number of enabled Clocks since the last restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_out_ctrl;

    localparam int H_SYNC   = 3;
    localparam int H_BACK   = 2;
    localparam int H_ACTIVE = 6;
    localparam int H_FRONT  = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 1;
    localparam int V_ACTIVE = 3;
    localparam int V_FRONT  = 2;
    localparam int HT       = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT       = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H0       = H_SYNC + H_BACK;
    localparam int V0       = V_SYNC + V_BACK;

    logic        Clock;
    logic        Resetn;
    logic        Enable;
    logic        Clock_en;
    logic [10:0] H_Count;
    logic [9:0]  V_Count;
    logic        oRead_out_en;
    logic [7:0]  R_in, G_in, B_in;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, Frame_start;

    vga_out_ctrl #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
    ) u_dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Clock_en(Clock_en),
        .H_Count(H_Count), .V_Count(V_Count), .oRead_out_en(oRead_out_en),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .Frame_start(Frame_start)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int          errors;
    int          checks;
    int          n;            // enabled Clock edges since last restart
    logic [23:0] cap_rgb;      // data on R/G/B_in during the current Clock
    logic [23:0] e_rgb;
    logic        e_blank, e_hs, e_vs;
    int          strobe_cnt;
    bit          frame_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int px_h(input int k);
        return (k / 2) % HT;
    endfunction

    function automatic int px_v(input int k);
        return (k / 2 / HT) % VT;
    endfunction

    // Pixel (h,v) whose Clock_en=0 half carries a strobe: the pixel just
    // before an active one, on active lines.
    function automatic bit fetch(input int h, input int v);
        return (v >= V0) && (v < V0 + V_ACTIVE) && (h >= H0 - 1) && (h <= H0 + H_ACTIVE - 2);
    endfunction

    // One Clock: model the edge, then drive the next inputs, then check at negedge.
    task automatic run_cycle(input logic en_next, input logic rstn_next);
        int h, v;
        @(posedge Clock);
        if (!Resetn || !Enable) begin
            n = 0; e_blank = 1'b0; e_rgb = 24'd0; e_hs = 1'b1; e_vs = 1'b1;
            strobe_cnt = 0; frame_valid = 1'b0;
        end else begin
            if (n % 2 == 1) begin
                h = px_h(n); v = px_v(n);
                e_blank = fetch(h, v);
                e_rgb   = e_blank ? cap_rgb : 24'd0;
                e_hs    = (h >= H_SYNC);
                e_vs    = (v >= V_SYNC);
            end
            n++;
        end
        #1;
        R_in = 8'($urandom); G_in = 8'($urandom); B_in = 8'($urandom);
        cap_rgb = {R_in, G_in, B_in};
        Enable = en_next;
        Resetn = rstn_next;
        @(negedge Clock);
        check_outputs();
    endtask

    task automatic check_outputs();
        int h, v;
        bit fs;
        h  = px_h(n);
        v  = px_v(n);
        fs = (n % 2 == 1) && (h == 0) && (v == 0);
        check("clock_en",    32'(Clock_en),     32'(n % 2));
        check("h_count",     32'(H_Count),      32'(h));
        check("v_count",     32'(V_Count),      32'(v));
        check("read_en",     32'(oRead_out_en), 32'((n % 2 == 0) && fetch(h, v)));
        check("frame_start", 32'(Frame_start),  32'(fs));
        check("rgb",         {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, e_rgb});
        check("blank_n",     32'(VGA_BLANK_N),  32'(e_blank));
        check("hs",          32'(VGA_HS),       32'(e_hs));
        check("vs",          32'(VGA_VS),       32'(e_vs));
        check("sync_n",      32'(VGA_SYNC_N),   32'd0);
        if (oRead_out_en) begin
            if (strobe_cnt == 0) begin
                check("first_strobe_h", 32'(H_Count), 32'(H0 - 1));
                check("first_strobe_v", 32'(V_Count), 32'(V0));
            end
            strobe_cnt++;
        end
        if (fs) begin
            if (frame_valid) check("frame_strobes", 32'(strobe_cnt), 32'(H_ACTIVE * V_ACTIVE));
            strobe_cnt  = 0;
            frame_valid = 1'b1;
        end
    endtask

    task automatic run_to(input int h, input int v, input bit odd);
        int budget;
        budget = 0;
        while (!(px_h(n) == h && px_v(n) == v && (n % 2 == 1) == odd) && budget < 1000) begin
            run_cycle(1'b1, 1'b1);
            budget++;
        end
        if (budget >= 1000) check("run_to_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        errors = 0; checks = 0; n = 0;
        e_blank = 1'b0; e_rgb = 24'd0; e_hs = 1'b1; e_vs = 1'b1;
        cap_rgb = 24'd0; strobe_cnt = 0; frame_valid = 1'b0;
        Resetn = 1'b0; Enable = 1'b0;
        R_in = 8'd0; G_in = 8'd0; B_in = 8'd0;

        // Reset state, then enable and release reset together.
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b1);

        // Several clean frames: raster, strobes, data, sync, frame pulses.
        repeat (3 * HT * VT * 2) run_cycle(1'b1, 1'b1);

        // Enable drop mid-active-line, held a few Clocks, then restart.
        run_to(H0 + 3, V0 + 1, 1'b0);
        run_cycle(1'b0, 1'b1);
        repeat (3) run_cycle(1'b0, 1'b1);
        run_cycle(1'b1, 1'b1);
        repeat (2 * HT * VT * 2) run_cycle(1'b1, 1'b1);

        // Asynchronous reset mid-active-line: outputs clear before any edge.
        run_to(H0 + 2, V0, 1'b1);
        #2;
        Resetn = 1'b0;
        #1;
        check("arst_clock_en", 32'(Clock_en),     32'd0);
        check("arst_h",        32'(H_Count),      32'd0);
        check("arst_v",        32'(V_Count),      32'd0);
        check("arst_read_en",  32'(oRead_out_en), 32'd0);
        check("arst_rgb",      {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check("arst_hs",       32'(VGA_HS),       32'd1);
        check("arst_vs",       32'(VGA_VS),       32'd1);
        check("arst_blank_n",  32'(VGA_BLANK_N),  32'd0);
        check("arst_frame",    32'(Frame_start),  32'd0);
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b1);

        // Random enable drops over the raster.
        for (int i = 0; i < 2500; i++) begin
            run_cycle(($urandom_range(0, 199) != 0), 1'b1);
        end

        // Finish with two clean frames after a guaranteed enabled period.
        repeat (2 * HT * VT * 2 + 4) run_cycle(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
